uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Controller between UART receiver, ALU and UART transmitter in the UART-ALU loopback design.
- Collects three received bytes in order (operand A, operand B, opcode) and commits them to the ALU inputs together.
- Captures the ALU result and sends it back through the transmitter with a start/done handshake.
- Inter-byte and transmit watchdog returns the sequencer to idle if a host or the transmitter stalls.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and result.
- NB_OP, 6, opcode width; taken from low NB_OP bits of the third byte.
- TIMEOUT_CYCLES, 1000000, i_clock cycles allowed between bytes, and while waiting for tx done.
- NB_TIMEOUT, 20, watchdog counter width; must satisfy 2**NB_TIMEOUT > TIMEOUT_CYCLES.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done_tick  in  1  one-cycle pulse: i_rx_data holds a new byte.
- i_rx_data  in  NB_DATA  received byte.
- i_alu_result  in  NB_DATA  combinational ALU result for current o_data_a/o_data_b/o_operation.
- i_tx_done_tick  in  1  one-cycle pulse: transmitter finished frame.
- o_data_a  out  NB_DATA  committed operand A to ALU.
- o_data_b  out  NB_DATA  committed operand B to ALU.
- o_operation  out  NB_OP  committed opcode to ALU.
- o_tx_start  out  1  one-cycle start pulse to transmitter.
- o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done_tick.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  one-cycle pulse when watchdog aborts a transaction.
- o_overrun  out  1  one-cycle pulse when a received byte is dropped.

Behaviour:
- Reset (i_reset high at a clock edge): state IDLE, all outputs 0, staging registers 0, watchdog 0. Reset has priority over every other event, including mid-transaction; the partial transaction is discarded and no pulse is issued.
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: rx tick -> stage byte as A, go GET_B.
- GET_B: rx tick -> stage byte as B, go GET_OP.
- GET_OP: rx tick -> commit staged A, staged B and i_rx_data[NB_OP-1:0] to o_data_a/o_data_b/o_operation in the same edge, go EXEC.
- The ALU outputs change only on commit; partial transactions never disturb them.
- EXEC (one cycle): latch i_alu_result into o_tx_data, go SEND.
- SEND (one cycle): o_tx_start = 1, go WAIT_TX.
- WAIT_TX: i_tx_done_tick -> go IDLE.
- Latency: opcode tick at cycle N -> ALU inputs valid at N+1 -> o_tx_start high during N+2.
- Watchdog:
  - Clears on every state change.
  - Counts in GET_B, GET_OP and WAIT_TX.
  - On reaching TIMEOUT_CYCLES-1 with no advancing event in that cycle, go IDLE and pulse o_timeout.
  - A GET_B/GET_OP abort leaves committed ALU outputs unchanged. A WAIT_TX abort keeps o_tx_data.
  - An advancing event in the final cycle wins over the timeout.
- Overrun: rx tick in EXEC, SEND or WAIT_TX drops the byte and pulses o_overrun. This includes an rx tick coincident with i_tx_done_tick; that byte is not taken as A.
- i_tx_done_tick outside WAIT_TX is ignored.
- o_busy is a registered decode of state (0 only in IDLE).

Decomposition:
- Shared package: state encoding localparams (3-bit), default NB_DATA/NB_OP/TIMEOUT values, and ALU opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100) for the bench.
- One sub-module: seq_watchdog, with inputs clear, enable and terminal count, and output expired.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with real ALU (ADD) -> o_operation = 6'b100000 at N+1; o_tx_start one pulse at N+2; o_tx_data = 0x08 held until tx done; then IDLE.
- Bytes 0x05, 0x07, 0x22 (SUB) -> o_tx_data = 0xFE; then a second transaction 0xF0, 0x0F, 0x24 (AND) back-to-back after tx done -> 0x00.
- TIMEOUT_CYCLES = 16: send 0x11, then nothing -> o_timeout pulse exactly 16 cycles after entering GET_B; ALU outputs keep prior values; state IDLE.
- During WAIT_TX inject an rx byte 0xAA -> o_overrun pulse, byte dropped. Next transaction 0x01, 0x01, 0x20 -> 0x02.
- Assert i_reset in GET_OP after A = 0x33 and B = 0x44 -> next cycle all outputs 0, no o_tx_start. The following 3-byte transaction completes normally.
- Withhold i_tx_done_tick (TIMEOUT_CYCLES = 16) -> o_timeout pulse, IDLE, o_tx_data retained. An i_tx_done_tick delivered in IDLE has no effect.

Source files
------------

// File: rtl/uart_alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer_pkg
// Shared definitions for the UART-ALU loopback sequencer:
//   - default widths and watchdog timeout
//   - 3-bit sequencer state encoding
//   - ALU opcode constants used by the host side and the bench
//   - helper deciding in which states the watchdog runs
// -----------------------------------------------------------------------------
package uart_alu_sequencer_pkg;

    localparam int DEF_NB_DATA        = 8;
    localparam int DEF_NB_OP          = 6;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_NB_TIMEOUT     = 20;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

    // ALU opcodes carried in the low bits of the third byte
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;

    // States in which the sequencer waits on an external party and may stall
    function automatic logic is_waiting_state(input state_e st);
        logic res;
        case (st)
            ST_GET_B, ST_GET_OP, ST_WAIT_TX: res = 1'b1;
            default:                         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Stall counter for the sequencer. Counts clock cycles while enabled and
// flags expiry in the cycle in which the count equals the terminal value.
// Ports:
//   i_clock     system clock
//   i_reset     synchronous, active-high reset
//   i_clear     restart counting from zero (state change)
//   i_enable    count in this cycle; when low the counter is held at zero
//   i_terminal  count value at which the watchdog fires
//   o_expired   high while enabled and count == terminal
// -----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int NB_TIMEOUT = 20
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_enable,
    input  logic [NB_TIMEOUT-1:0] i_terminal,
    output logic                  o_expired
);

    logic [NB_TIMEOUT-1:0] count_q;

    // Cycle counter: cleared on reset, on request or whenever not counting
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (i_clear || !i_enable) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + NB_TIMEOUT'(1);
        end
    end

    // Expiry is an in-cycle decode so the owner can give priority to a
    // coincident advancing event.
    assign o_expired = i_enable && (count_q == i_terminal);

endmodule

// File: rtl/uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer
// Sits between UART receiver, ALU and UART transmitter. Collects operand A,
// operand B and opcode bytes, commits all three to the ALU together, captures
// the ALU result and hands it to the transmitter with a start/done handshake.
// A watchdog returns to idle if the host stalls between bytes or the
// transmitter never reports done.
// Ports:
//   i_clock, i_reset     clock, synchronous active-high reset
//   i_rx_done_tick       pulse: i_rx_data holds a new byte
//   i_rx_data            received byte
//   i_alu_result         combinational ALU result for committed inputs
//   i_tx_done_tick       pulse: transmitter finished its frame
//   o_data_a/o_data_b    committed ALU operands
//   o_operation          committed ALU opcode
//   o_tx_start           one-cycle start pulse to transmitter
//   o_tx_data            byte to transmit
//   o_busy               high whenever not idle
//   o_timeout            pulse when the watchdog aborts a transaction
//   o_overrun            pulse when a received byte is dropped
// -----------------------------------------------------------------------------
module uart_alu_sequencer
    import uart_alu_sequencer_pkg::*;
#(
    parameter int NB_DATA        = DEF_NB_DATA,
    parameter int NB_OP          = DEF_NB_OP,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int NB_TIMEOUT     = DEF_NB_TIMEOUT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    localparam logic [NB_TIMEOUT-1:0] WD_TERMINAL = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_e             state_q;
    logic [NB_DATA-1:0] stage_a_q;
    logic [NB_DATA-1:0] stage_b_q;
    logic [NB_DATA-1:0] data_a_q;
    logic [NB_DATA-1:0] data_b_q;
    logic [NB_OP-1:0]   operation_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               timeout_q;
    logic               overrun_q;

    logic advance_s;
    logic wd_enable_s;
    logic wd_clear_s;
    logic wd_expired_s;

    // Decode whether the current state leaves in this cycle on its own event
    always_comb begin
        advance_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_GET_B, ST_GET_OP: advance_s = i_rx_done_tick;
            ST_EXEC, ST_SEND:             advance_s = 1'b1;
            ST_WAIT_TX:                   advance_s = i_tx_done_tick;
            default:                      advance_s = 1'b1;
        endcase
    end

    // Any state change (advance or abort) restarts the watchdog
    assign wd_enable_s = is_waiting_state(state_q);
    assign wd_clear_s  = advance_s || wd_expired_s;

    seq_watchdog #(
        .NB_TIMEOUT (NB_TIMEOUT)
    ) u_watchdog (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (wd_clear_s),
        .i_enable   (wd_enable_s),
        .i_terminal (WD_TERMINAL),
        .o_expired  (wd_expired_s)
    );

    // Sequencer FSM with registered outputs; advancing events beat the watchdog
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            stage_a_q   <= '0;
            stage_b_q   <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            operation_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_done_tick) begin
                        stage_a_q <= i_rx_data;
                        state_q   <= ST_GET_B;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                ST_GET_B: begin
                    if (i_rx_done_tick) begin
                        stage_b_q <= i_rx_data;
                        state_q   <= ST_GET_OP;
                        busy_q    <= 1'b1;
                    end else if (wd_expired_s) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q   <= ST_GET_B;
                        busy_q    <= 1'b1;
                    end
                end
                ST_GET_OP: begin
                    if (i_rx_done_tick) begin
                        // All three ALU inputs change on the same edge
                        data_a_q    <= stage_a_q;
                        data_b_q    <= stage_b_q;
                        operation_q <= i_rx_data[NB_OP-1:0];
                        state_q     <= ST_EXEC;
                        busy_q      <= 1'b1;
                    end else if (wd_expired_s) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q   <= ST_GET_OP;
                        busy_q    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Result and start are registered together so the start
                    // pulse is visible during the SEND cycle.
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    overrun_q  <= i_rx_done_tick;
                    state_q    <= ST_SEND;
                    busy_q     <= 1'b1;
                end
                ST_SEND: begin
                    overrun_q <= i_rx_done_tick;
                    state_q   <= ST_WAIT_TX;
                    busy_q    <= 1'b1;
                end
                ST_WAIT_TX: begin
                    // A byte arriving with tx done is still dropped
                    overrun_q <= i_rx_done_tick;
                    if (i_tx_done_tick) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end else if (wd_expired_s) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        state_q   <= ST_WAIT_TX;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_operation = operation_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench: transaction-level reference model plus directed and
// random host/transmitter traffic.
module tb_uart_alu_sequencer;
    import uart_alu_sequencer_pkg::*;

    localparam int TO  = 16;
    localparam int NBT = 5;

    logic       clk = 1'b0;
    logic       rst, rx, txd;
    logic [7:0] rxd, alu_res;
    logic [7:0] o_data_a, o_data_b, o_tx_data;
    logic [5:0] o_operation;
    logic       o_tx_start, o_busy, o_timeout, o_overrun;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_res = alu_fn(o_data_a, o_data_b, o_operation);

    uart_alu_sequencer #(
        .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TO), .NB_TIMEOUT(NBT)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_done_tick(rx), .i_rx_data(rxd),
        .i_alu_result(alu_res), .i_tx_done_tick(txd),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_operation(o_operation),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
        .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: how many bytes are collected, where the reply is in its
    // journey (0 none, 1 computing, 2 start issued, 3 awaiting done), and how
    // long the current wait has lasted.
    int         m_nb, m_ph, m_wd;
    logic [7:0] m_sa, m_sb, e_a, e_b, e_txd;
    logic [5:0] e_op;
    bit         e_start, e_busy, e_to, e_ovr;

    initial begin
        m_nb = 0; m_ph = 0; m_wd = 0; m_sa = 8'h00; m_sb = 8'h00;
        e_a = 8'h00; e_b = 8'h00; e_txd = 8'h00; e_op = 6'h00;
        e_start = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
        forever begin
            @(posedge clk);
            e_start = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
            if (rst) begin
                m_nb = 0; m_ph = 0; m_wd = 0; m_sa = 8'h00; m_sb = 8'h00;
                e_a = 8'h00; e_b = 8'h00; e_txd = 8'h00; e_op = 6'h00;
            end else if (m_ph == 0) begin
                if (rx) begin
                    if (m_nb == 0) begin
                        m_sa = rxd; m_nb = 1;
                    end else if (m_nb == 1) begin
                        m_sb = rxd; m_nb = 2;
                    end else begin
                        e_a = m_sa; e_b = m_sb; e_op = rxd[5:0]; m_nb = 0; m_ph = 1;
                    end
                    m_wd = 0;
                end else if (m_nb > 0) begin
                    if (m_wd == TO - 1) begin
                        m_nb = 0; e_to = 1'b1; m_wd = 0;
                    end else begin
                        m_wd++;
                    end
                end
            end else if (m_ph == 1) begin
                e_txd = alu_fn(e_a, e_b, e_op); e_start = 1'b1; m_ph = 2; e_ovr = rx;
            end else if (m_ph == 2) begin
                m_ph = 3; m_wd = 0; e_ovr = rx;
            end else begin
                e_ovr = rx;
                if (txd) begin
                    m_ph = 0; m_wd = 0;
                end else if (m_wd == TO - 1) begin
                    m_ph = 0; e_to = 1'b1; m_wd = 0;
                end else begin
                    m_wd++;
                end
            end
            e_busy = (m_nb > 0) || (m_ph > 0);
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_data_a",   o_data_a,    e_a);
                chk("m_data_b",   o_data_b,    e_b);
                chk("m_op",       o_operation, e_op);
                chk("m_tx_data",  o_tx_data,   e_txd);
                chk("m_tx_start", o_tx_start,  e_start);
                chk("m_busy",     o_busy,      e_busy);
                chk("m_timeout",  o_timeout,   e_to);
                chk("m_overrun",  o_overrun,   e_ovr);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx = 1'b1; rxd = b; step(); rx = 1'b0;
    endtask

    task automatic done_pulse();
        txd = 1'b1; step(); txd = 1'b0;
    endtask

    int k;
    int quiet;

    initial begin
        rst = 1'b1; rx = 1'b0; txd = 1'b0; rxd = 8'h00;
        repeat (2) step();
        rst = 1'b0; cmp_en = 1'b1;
        chk("rst_busy", o_busy, 32'd0);
        chk("rst_txd",  o_tx_data, 32'd0);
        chk("rst_op",   o_operation, 32'd0);

        // ADD 5 + 3
        send(8'h05); send(8'h03); send(8'h20);
        chk("add_op", o_operation, 32'h20);
        chk("add_a", o_data_a, 32'h05);
        chk("add_start_early", o_tx_start, 32'd0);
        step();
        chk("add_start", o_tx_start, 32'd1);
        chk("add_res", o_tx_data, 32'h08);
        repeat (3) step();
        chk("add_start_single", o_tx_start, 32'd0);
        chk("add_hold", o_tx_data, 32'h08);
        done_pulse();
        chk("add_idle", o_busy, 32'd0);

        // SUB 5 - 7 then AND back to back
        send(8'h05); send(8'h07); send(8'h22);
        step();
        chk("sub_res", o_tx_data, 32'hFE);
        step(); done_pulse();
        send(8'hF0); send(8'h0F); send(8'h24);
        step();
        chk("and_res", o_tx_data, 32'h00);
        step(); done_pulse();

        // Stall between bytes
        send(8'h11);
        k = 0;
        while (k < 40 && !o_timeout) begin step(); k++; end
        chk("getb_timeout_cycles", k, 32'd16);
        chk("getb_keep_a", o_data_a, 32'hF0);
        chk("getb_keep_op", o_operation, 32'h24);
        chk("getb_idle", o_busy, 32'd0);

        // Overrun while awaiting tx done
        send(8'h09); send(8'h02); send(8'h22);
        step(); step();
        rx = 1'b1; rxd = 8'hAA; step(); rx = 1'b0;
        chk("ovr_pulse", o_overrun, 32'd1);
        chk("ovr_busy", o_busy, 32'd1);
        done_pulse();
        send(8'h01); send(8'h01); send(8'h20);
        step();
        chk("after_ovr_res", o_tx_data, 32'h02);
        step(); done_pulse();

        // Reset mid-transaction
        send(8'h33); send(8'h44);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_a", o_data_a, 32'd0);
        chk("mid_rst_txd", o_tx_data, 32'd0);
        chk("mid_rst_start", o_tx_start, 32'd0);
        chk("mid_rst_busy", o_busy, 32'd0);
        send(8'h0A); send(8'h05); send(8'h22);
        step();
        chk("post_rst_res", o_tx_data, 32'h05);
        step(); done_pulse();

        // Transmitter never finishes
        send(8'h10); send(8'h20); send(8'h20);
        step();
        k = 0;
        while (k < 40 && !o_timeout) begin step(); k++; end
        chk("tx_timeout_cycles", k, 32'd17);
        chk("tx_timeout_keep", o_tx_data, 32'h30);
        chk("tx_timeout_idle", o_busy, 32'd0);
        done_pulse();
        chk("stray_done_busy", o_busy, 32'd0);
        chk("stray_done_start", o_tx_start, 32'd0);

        // Random traffic
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            if (quiet == 0 && $urandom_range(149, 0) == 0) quiet = 25;
            rst = ($urandom_range(599, 0) == 0);
            rx  = (quiet == 0) && ($urandom_range(2, 0) == 0);
            rxd = 8'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                case ($urandom_range(2, 0))
                    0:       rxd[5:0] = OP_ADD;
                    1:       rxd[5:0] = OP_SUB;
                    default: rxd[5:0] = OP_AND;
                endcase
            end
            txd = ($urandom_range(4, 0) == 0);
            step();
            if (quiet > 0) quiet--;
        end
        rst = 1'b0; rx = 1'b0; txd = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
